rv_cpu_core: RTL and testbench
==============================

# rv_cpu_core

Five-stage in-order RV32I integer pipeline: IF (Q100H), ID (Q101H), EXE (Q102H), MA (Q103H), WB (Q104H). It sits between a combinational-read instruction ROM and a combinational-read, clocked-write data RAM. It contains the PC, the 32×32 register file, the ALU, forwarding and hazard logic. Stage-qualified signal names use the QxxxH suffix.

## Interface
- No parameters. Reset PC is fixed at 0x0000_0000.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address of the fetch (pc_Q100H).
- imem_rd_data  in  32  instruction at imem_addr, valid in the same cycle.
- core2dmem_req  out  t_core2mem_req  data request: address[31:0], wr_data[31:0], wr_en, rd_en. Driven from Q103H.
- dmem_rd_data  in  32  word at core2dmem_req.address, valid in the same cycle.

## Operation
- ISA: R-type ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- I-type ALU: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
- Memory: LW and SW, word only. Effective address is rs1 + sign-extended imm.
- Control flow: BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR, LUI, AUIPC.
- Any other opcode executes as a NOP: no register write, no memory access.
- IF: imem_addr = pc_Q100H. next_pc_Q100H = pc_Q100H + 4, unless a redirect is taken in EXE.
- ID:
  - Decode fields rs1/rs2/rd and build the immediate (I/S/B/U/J, sign-extended).
  - Read the register file. x0 always reads 0; writes to x0 are ignored.
  - The register file is write-through: if WB writes the register that ID reads in the same cycle, ID sees the new value.
- EXE: the ALU computes alu_out_Q102H.
  - Inputs: alu_in1 = rs1 data or PC (AUIPC/JAL). alu_in2 = rs2 data or immediate.
  - The branch condition and targets are resolved in EXE.
  - JAL/JALR write PC+4 to rd. The JALR target has bit 0 cleared.
- Forwarding into the EXE operands, in priority order: Q103H result (ALU result only), then Q104H wb_data, then the register file value.
  - Forwarding applies only when the producer's reg_write_en = 1 and its rd ≠ 0.
- Load-use hazard: if EXE holds an LW whose rd equals a source of the instruction in ID:
  - hold PC and the IF/ID register for 1 cycle;
  - insert a bubble into EXE;
  - the load data is then forwarded from Q104H.
- Taken branch or jump: redirect the PC and flush the two younger instructions (IF/ID and ID/EXE become bubbles).
- MA:
  - core2dmem_req.address = alu_out_Q103H.
  - wr_data = forwarded rs2 value.
  - wr_en = 1 only for SW; rd_en = 1 only for LW.
  - The RAM writes on the clock edge that ends Q103H.
- WB: wb_data_Q104H = dmem read data registered from MA (LW), or alu_out / PC+4.
  - The register file writes rd at the clock edge that ends Q104H when reg_write_en_Q104H = 1.

## Timing
- While rst = 0:
  - pc_Q100H = 0, so imem_addr = 0;
  - all pipeline registers hold bubbles (reg_write_en = 0, wr_en = 0, rd_en = 0);
  - the register file clears to 0.
- Reset asserted mid-operation clears all of the above immediately (asynchronous). Data-memory contents are external and are not touched.
- After reset release, the instruction at address 0 is in Q101H on the 1st edge and in Q104H after the 4th edge. Its register write lands at the 5th edge.
- Latency without hazards:
  - 1 instruction per cycle;
  - 0 cycles for back-to-back ALU dependencies;
  - 1 stall cycle for load-use.
- Taken branch/jump penalty: 2 cycles.
- No handshakes: both memories always respond in the same cycle.

## Test plan
- Reset hold: while rst = 0, imem_addr = 0 and wr_en = rd_en = 0. After release, the PC steps 0, 4, 8, ...
- Program, run ≥ 20 cycles:
  - ADDI x1,x0,10; ADDI x2,x0,20; ADD x3,x1,x2; SUB x4,x2,x1; SW x3,0(x0); LW x5,0(x0); NOP; ADDI x6,x5,5;
  - required result: x1=10, x2=20, x3=30, x4=10, x5=30, x6=35, mem[0]=30;
  - this exercises forwarding from both MA and WB.
- Load-use without a NOP: LW x5,0(x0) immediately followed by ADDI x6,x5,5 → exactly one stall cycle, then x6 = mem[0]+5.
- Branch: BEQ x0,x0,+8 → the next sequential instruction is never written back, and execution resumes at the target.
- JAL x1,+12 at 0x20 → x1 = 0x24 and the PC goes to 0x2C. Also JALR to an odd address → bit 0 is cleared.
- x0 protection: ADDI x0,x0,5 then ADD x7,x0,x0 → x7 = 0, with no forwarding from x0.

Source files
------------

// File: rtl/rv_cpu_core.sv
// rv_cpu_core: five-stage in-order RV32I pipeline (IF/ID/EXE/MA/WB)
// with MA/WB operand forwarding, load-use stall and EXE redirects.
package rv_cpu_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wr_data;
        logic        wr_en;
        logic        rd_en;
    } t_core2mem_req;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } t_alu_op;

    typedef enum logic [1:0] {
        IN1_RS1, IN1_PC, IN1_ZERO
    } t_in1_sel;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic        reg_write_en;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        t_alu_op     alu_op;
        t_in1_sel    in1_sel;
        logic        imm_in2;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } t_id_ex;

    typedef struct packed {
        logic        reg_write_en;
        logic        is_load;
        logic        is_store;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
    } t_ex_ma;

    typedef struct packed {
        logic        reg_write_en;
        logic [4:0]  rd;
        logic [31:0] wb_data;
    } t_ma_wb;

    function automatic t_alu_op alu_op_of(input logic [2:0] f3,
                                          input logic alt);
        t_alu_op op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

module rv_cpu_core
    import rv_cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rd_data,
    output t_core2mem_req core2dmem_req,
    input  logic [31:0]   dmem_rd_data
);

    logic [31:0] pc_Q100H;
    logic [31:0] next_pc_Q100H;

    logic        valid_Q101H;
    logic [31:0] pc_Q101H;
    logic [31:0] instr_Q101H;

    t_id_ex      id_Q101H;
    t_id_ex      ex_Q102H;
    t_ex_ma      ma_Q103H;
    t_ma_wb      wb_Q104H;

    logic [31:0] rf [32];

    logic [6:0]  opcode_Q101H;
    logic [2:0]  funct3_Q101H;
    logic [4:0]  rs1_Q101H;
    logic [4:0]  rs2_Q101H;
    logic [31:0] imm_i_Q101H;
    logic [31:0] imm_s_Q101H;
    logic [31:0] imm_b_Q101H;
    logic [31:0] imm_u_Q101H;
    logic [31:0] imm_j_Q101H;
    logic [31:0] rs1_data_Q101H;
    logic [31:0] rs2_data_Q101H;
    logic        use_rs1_Q101H;
    logic        use_rs2_Q101H;
    logic        load_use_Q101H;

    logic [31:0] fwd_a_Q102H;
    logic [31:0] fwd_b_Q102H;
    logic [31:0] alu_in1_Q102H;
    logic [31:0] alu_in2_Q102H;
    logic [31:0] alu_out_Q102H;
    logic [31:0] result_Q102H;
    logic        br_cond_Q102H;
    logic        redirect_Q102H;
    logic [31:0] redirect_pc_Q102H;

    // ---------------- IF ----------------
    assign imem_addr = pc_Q100H;

    always_comb begin
        next_pc_Q100H = pc_Q100H + 32'd4;
        if (redirect_Q102H) begin
            next_pc_Q100H = redirect_pc_Q102H;
        end else if (load_use_Q101H) begin
            next_pc_Q100H = pc_Q100H;
        end
    end

    // ---------------- ID ----------------
    assign opcode_Q101H = instr_Q101H[6:0];
    assign funct3_Q101H = instr_Q101H[14:12];
    assign rs1_Q101H    = instr_Q101H[19:15];
    assign rs2_Q101H    = instr_Q101H[24:20];

    assign imm_i_Q101H = {{20{instr_Q101H[31]}}, instr_Q101H[31:20]};
    assign imm_s_Q101H = {{20{instr_Q101H[31]}}, instr_Q101H[31:25],
                          instr_Q101H[11:7]};
    assign imm_b_Q101H = {{19{instr_Q101H[31]}}, instr_Q101H[31],
                          instr_Q101H[7], instr_Q101H[30:25],
                          instr_Q101H[11:8], 1'b0};
    assign imm_u_Q101H = {instr_Q101H[31:12], 12'b0};
    assign imm_j_Q101H = {{11{instr_Q101H[31]}}, instr_Q101H[31],
                          instr_Q101H[19:12], instr_Q101H[20],
                          instr_Q101H[30:21], 1'b0};

    // Write-through: a WB write in this cycle is visible to the ID read
    always_comb begin
        rs1_data_Q101H = rf[rs1_Q101H];
        if (rs1_Q101H == 5'd0) begin
            rs1_data_Q101H = '0;
        end else if (wb_Q104H.reg_write_en && wb_Q104H.rd == rs1_Q101H) begin
            rs1_data_Q101H = wb_Q104H.wb_data;
        end
        rs2_data_Q101H = rf[rs2_Q101H];
        if (rs2_Q101H == 5'd0) begin
            rs2_data_Q101H = '0;
        end else if (wb_Q104H.reg_write_en && wb_Q104H.rd == rs2_Q101H) begin
            rs2_data_Q101H = wb_Q104H.wb_data;
        end
    end

    always_comb begin
        id_Q101H          = '0;
        id_Q101H.pc       = pc_Q101H;
        id_Q101H.funct3   = funct3_Q101H;
        id_Q101H.rd       = instr_Q101H[11:7];
        id_Q101H.rs1      = rs1_Q101H;
        id_Q101H.rs2      = rs2_Q101H;
        id_Q101H.rs1_data = rs1_data_Q101H;
        id_Q101H.rs2_data = rs2_data_Q101H;
        use_rs1_Q101H     = 1'b0;
        use_rs2_Q101H     = 1'b0;
        if (valid_Q101H) begin
            unique case (opcode_Q101H)
                OPC_OP: begin
                    id_Q101H.reg_write_en = 1'b1;
                    id_Q101H.alu_op = alu_op_of(funct3_Q101H, instr_Q101H[30]);
                    use_rs1_Q101H = 1'b1;
                    use_rs2_Q101H = 1'b1;
                end
                OPC_OP_IMM: begin
                    id_Q101H.reg_write_en = 1'b1;
                    id_Q101H.alu_op = alu_op_of(funct3_Q101H,
                        funct3_Q101H == 3'b101 && instr_Q101H[30]);
                    id_Q101H.imm_in2 = 1'b1;
                    id_Q101H.imm = imm_i_Q101H;
                    use_rs1_Q101H = 1'b1;
                end
                OPC_LOAD: begin
                    if (funct3_Q101H == 3'b010) begin
                        id_Q101H.reg_write_en = 1'b1;
                        id_Q101H.is_load = 1'b1;
                        id_Q101H.imm_in2 = 1'b1;
                        id_Q101H.imm = imm_i_Q101H;
                        use_rs1_Q101H = 1'b1;
                    end
                end
                OPC_STORE: begin
                    if (funct3_Q101H == 3'b010) begin
                        id_Q101H.is_store = 1'b1;
                        id_Q101H.imm_in2 = 1'b1;
                        id_Q101H.imm = imm_s_Q101H;
                        use_rs1_Q101H = 1'b1;
                        use_rs2_Q101H = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    id_Q101H.is_branch = 1'b1;
                    id_Q101H.imm = imm_b_Q101H;
                    use_rs1_Q101H = 1'b1;
                    use_rs2_Q101H = 1'b1;
                end
                OPC_JAL: begin
                    id_Q101H.reg_write_en = 1'b1;
                    id_Q101H.is_jump = 1'b1;
                    id_Q101H.in1_sel = IN1_PC;
                    id_Q101H.imm_in2 = 1'b1;
                    id_Q101H.imm = imm_j_Q101H;
                end
                OPC_JALR: begin
                    id_Q101H.reg_write_en = 1'b1;
                    id_Q101H.is_jump = 1'b1;
                    id_Q101H.imm_in2 = 1'b1;
                    id_Q101H.imm = imm_i_Q101H;
                    use_rs1_Q101H = 1'b1;
                end
                OPC_LUI: begin
                    id_Q101H.reg_write_en = 1'b1;
                    id_Q101H.in1_sel = IN1_ZERO;
                    id_Q101H.imm_in2 = 1'b1;
                    id_Q101H.imm = imm_u_Q101H;
                end
                OPC_AUIPC: begin
                    id_Q101H.reg_write_en = 1'b1;
                    id_Q101H.in1_sel = IN1_PC;
                    id_Q101H.imm_in2 = 1'b1;
                    id_Q101H.imm = imm_u_Q101H;
                end
                default: ;
            endcase
        end
    end

    assign load_use_Q101H = ex_Q102H.is_load && ex_Q102H.rd != 5'd0 &&
        ((use_rs1_Q101H && ex_Q102H.rd == rs1_Q101H) ||
         (use_rs2_Q101H && ex_Q102H.rd == rs2_Q101H));

    // ---------------- EXE ----------------
    // A load in MA has no data yet; the stall keeps it from being needed here
    always_comb begin
        fwd_a_Q102H = ex_Q102H.rs1_data;
        if (ma_Q103H.reg_write_en && !ma_Q103H.is_load &&
            ma_Q103H.rd != 5'd0 && ma_Q103H.rd == ex_Q102H.rs1) begin
            fwd_a_Q102H = ma_Q103H.result;
        end else if (wb_Q104H.reg_write_en && wb_Q104H.rd != 5'd0 &&
                     wb_Q104H.rd == ex_Q102H.rs1) begin
            fwd_a_Q102H = wb_Q104H.wb_data;
        end
        fwd_b_Q102H = ex_Q102H.rs2_data;
        if (ma_Q103H.reg_write_en && !ma_Q103H.is_load &&
            ma_Q103H.rd != 5'd0 && ma_Q103H.rd == ex_Q102H.rs2) begin
            fwd_b_Q102H = ma_Q103H.result;
        end else if (wb_Q104H.reg_write_en && wb_Q104H.rd != 5'd0 &&
                     wb_Q104H.rd == ex_Q102H.rs2) begin
            fwd_b_Q102H = wb_Q104H.wb_data;
        end
    end

    always_comb begin
        unique case (ex_Q102H.in1_sel)
            IN1_PC:   alu_in1_Q102H = ex_Q102H.pc;
            IN1_ZERO: alu_in1_Q102H = '0;
            default:  alu_in1_Q102H = fwd_a_Q102H;
        endcase
        alu_in2_Q102H = ex_Q102H.imm_in2 ? ex_Q102H.imm : fwd_b_Q102H;
    end

    always_comb begin
        alu_out_Q102H = alu_in1_Q102H + alu_in2_Q102H;
        unique case (ex_Q102H.alu_op)
            ALU_SUB:  alu_out_Q102H = alu_in1_Q102H - alu_in2_Q102H;
            ALU_SLL:  alu_out_Q102H = alu_in1_Q102H << alu_in2_Q102H[4:0];
            ALU_SLT:  alu_out_Q102H = {31'b0,
                $signed(alu_in1_Q102H) < $signed(alu_in2_Q102H)};
            ALU_SLTU: alu_out_Q102H = {31'b0, alu_in1_Q102H < alu_in2_Q102H};
            ALU_XOR:  alu_out_Q102H = alu_in1_Q102H ^ alu_in2_Q102H;
            ALU_SRL:  alu_out_Q102H = alu_in1_Q102H >> alu_in2_Q102H[4:0];
            ALU_SRA:  alu_out_Q102H = 32'($signed(alu_in1_Q102H)
                                          >>> alu_in2_Q102H[4:0]);
            ALU_OR:   alu_out_Q102H = alu_in1_Q102H | alu_in2_Q102H;
            ALU_AND:  alu_out_Q102H = alu_in1_Q102H & alu_in2_Q102H;
            default:  ;
        endcase
    end

    always_comb begin
        unique case (ex_Q102H.funct3)
            3'b000:  br_cond_Q102H = fwd_a_Q102H == fwd_b_Q102H;
            3'b001:  br_cond_Q102H = fwd_a_Q102H != fwd_b_Q102H;
            3'b100:  br_cond_Q102H = $signed(fwd_a_Q102H) < $signed(fwd_b_Q102H);
            3'b101:  br_cond_Q102H = $signed(fwd_a_Q102H) >= $signed(fwd_b_Q102H);
            3'b110:  br_cond_Q102H = fwd_a_Q102H < fwd_b_Q102H;
            3'b111:  br_cond_Q102H = fwd_a_Q102H >= fwd_b_Q102H;
            default: br_cond_Q102H = 1'b0;
        endcase
    end

    assign redirect_Q102H = ex_Q102H.is_jump ||
                            (ex_Q102H.is_branch && br_cond_Q102H);
    assign redirect_pc_Q102H = ex_Q102H.is_branch ?
        ex_Q102H.pc + ex_Q102H.imm : {alu_out_Q102H[31:1], 1'b0};
    assign result_Q102H = ex_Q102H.is_jump ?
        ex_Q102H.pc + 32'd4 : alu_out_Q102H;

    // ---------------- MA ----------------
    assign core2dmem_req.address = ma_Q103H.result;
    assign core2dmem_req.wr_data = ma_Q103H.store_data;
    assign core2dmem_req.wr_en   = ma_Q103H.is_store;
    assign core2dmem_req.rd_en   = ma_Q103H.is_load;

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_Q100H    <= '0;
            valid_Q101H <= 1'b0;
            pc_Q101H    <= '0;
            instr_Q101H <= '0;
            ex_Q102H    <= '0;
            ma_Q103H    <= '0;
            wb_Q104H    <= '0;
        end else begin
            pc_Q100H <= next_pc_Q100H;
            if (redirect_Q102H) begin
                valid_Q101H <= 1'b0;
            end else if (!load_use_Q101H) begin
                valid_Q101H <= 1'b1;
                pc_Q101H    <= pc_Q100H;
                instr_Q101H <= imem_rd_data;
            end
            ex_Q102H <= (redirect_Q102H || load_use_Q101H) ? '0 : id_Q101H;
            ma_Q103H.reg_write_en <= ex_Q102H.reg_write_en;
            ma_Q103H.is_load      <= ex_Q102H.is_load;
            ma_Q103H.is_store     <= ex_Q102H.is_store;
            ma_Q103H.rd           <= ex_Q102H.rd;
            ma_Q103H.result       <= result_Q102H;
            ma_Q103H.store_data   <= fwd_b_Q102H;
            wb_Q104H.reg_write_en <= ma_Q103H.reg_write_en;
            wb_Q104H.rd           <= ma_Q103H.rd;
            wb_Q104H.wb_data      <= ma_Q103H.is_load ? dmem_rd_data
                                                      : ma_Q103H.result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_Q104H.reg_write_en && wb_Q104H.rd != 5'd0) begin
            rf[wb_Q104H.rd] <= wb_Q104H.wb_data;
        end
    end

endmodule

// File: tb/tb_rv_cpu_core.sv
// Bench for rv_cpu_core: ISA-level reference model, memory-request
// scoreboard, directed hazard/control programs and random programs.
module tb_rv_cpu_core;
    import rv_cpu_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rd_data;
    t_core2mem_req core2dmem_req;
    logic [31:0]   dmem_rd_data;

    logic [31:0] imem [256];
    logic [31:0] dmem [128];
    logic [31:0] dmem_seed [128];
    logic        dmem_init = 1'b0;

    logic [31:0] m_reg [32];
    logic [31:0] m_mem [128];
    logic [31:0] trace [8];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } t_mem_ev;
    t_mem_ev exp_q[$];
    t_mem_ev mon_ev;

    int passed = 0;
    int total  = 0;

    rv_cpu_core dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rd_data  (imem_rd_data),
        .core2dmem_req (core2dmem_req),
        .dmem_rd_data  (dmem_rd_data)
    );

    always #5 clk = ~clk;

    assign imem_rd_data = imem[imem_addr[9:2]];
    assign dmem_rd_data = dmem[core2dmem_req.address[8:2]];

    always @(posedge clk) begin
        if (dmem_init) begin
            for (int i = 0; i < 128; i++) dmem[i] <= dmem_seed[i];
        end else if (core2dmem_req.wr_en) begin
            dmem[core2dmem_req.address[8:2]] <= core2dmem_req.wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && (core2dmem_req.wr_en || core2dmem_req.rd_en)) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL mem_unexpected: got addr %h expected none",
                         core2dmem_req.address);
            end else begin
                mon_ev = exp_q.pop_front();
                check("mem_we", {31'b0, core2dmem_req.wr_en},
                      {31'b0, mon_ev.we});
                check("mem_addr", core2dmem_req.address, mon_ev.addr);
                if (mon_ev.we)
                    check("mem_wdata", core2dmem_req.wr_data, mon_ev.data);
            end
        end
    end

    function automatic logic [31:0] enc_r(input int f7, input int rs2,
        input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1,
        input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2,
        input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int f3,
        input int rs1, input int rs2);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3,
        input logic alt, input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: begin
                if (alt) return 32'($signed(x) >>> y[4:0]);
                return x >> y[4:0];
            end
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Architectural execution until the JAL x0,0 halt loop
    task automatic run_model();
        logic [31:0] pc, nxt, ins, a, b, res, addr;
        logic [31:0] ii, is, ib, iu, ij;
        logic        wr, tk;
        pc = 0;
        for (int s = 0; s < 2000; s++) begin
            ins = imem[pc[9:2]];
            if (ins == 32'h0000006f) break;
            a  = m_reg[ins[19:15]];
            b  = m_reg[ins[24:20]];
            ii = {{20{ins[31]}}, ins[31:20]};
            is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            iu = {ins[31:12], 12'b0};
            ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            wr = 0; res = 0; nxt = pc + 4;
            case (ins[6:0])
                7'h33: begin wr = 1; res = m_alu(ins[14:12], ins[30], a, b); end
                7'h13: begin
                    wr = 1;
                    res = m_alu(ins[14:12], ins[14:12] == 3'd5 && ins[30], a, ii);
                end
                7'h03: if (ins[14:12] == 3'd2) begin
                    addr = a + ii; wr = 1; res = m_mem[addr[8:2]];
                    exp_q.push_back('{0, addr, 32'd0});
                end
                7'h23: if (ins[14:12] == 3'd2) begin
                    addr = a + is; m_mem[addr[8:2]] = b;
                    exp_q.push_back('{1, addr, b});
                end
                7'h63: begin
                    case (ins[14:12])
                        3'd0: tk = a == b;
                        3'd1: tk = a != b;
                        3'd4: tk = $signed(a) < $signed(b);
                        3'd5: tk = $signed(a) >= $signed(b);
                        3'd6: tk = a < b;
                        3'd7: tk = a >= b;
                        default: tk = 0;
                    endcase
                    if (tk) nxt = pc + ib;
                end
                7'h6f: begin wr = 1; res = pc + 4; nxt = pc + ij; end
                7'h67: begin wr = 1; res = pc + 4; nxt = (a + ii) & ~32'd1; end
                7'h37: begin wr = 1; res = iu; end
                7'h17: begin wr = 1; res = pc + iu; end
                default: ;
            endcase
            if (wr && ins[11:7] != 0) m_reg[ins[11:7]] = res;
            pc = nxt;
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000006f;
        for (int i = 0; i < 128; i++) dmem_seed[i] = $urandom;
    endtask

    task automatic run_phase(input string tag, input int cycles);
        logic ok;
        rst = 0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        for (int i = 0; i < 128; i++) m_mem[i] = dmem_seed[i];
        run_model();
        dmem_init = 1;
        repeat (3) @(negedge clk);
        dmem_init = 0;
        check({tag, "_rst_pc"}, imem_addr, 32'd0);
        check({tag, "_rst_we"}, {31'b0, core2dmem_req.wr_en}, 32'd0);
        check({tag, "_rst_re"}, {31'b0, core2dmem_req.rd_en}, 32'd0);
        rst = 1;
        #1 trace[0] = imem_addr;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            trace[k] = imem_addr;
        end
        repeat (cycles) @(negedge clk);
        for (int r = 1; r < 32; r++)
            check($sformatf("%s_x%0d", tag, r), dut.rf[r], m_reg[r]);
        check({tag, "_memq_left"}, exp_q.size(), 32'd0);
        ok = 1;
        for (int i = 0; i < 128; i++) if (dmem[i] !== m_mem[i]) ok = 0;
        check({tag, "_dmem"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic gen_random(input int n);
        int sel, rd, rs1, rs2, f3, alt, imm;
        int bf3 [6] = '{0, 1, 4, 5, 6, 7};
        clear_imem();
        imem[0] = enc_i(256, 0, 0, 31, 7'h13);
        for (int i = 1; i < n; i++) begin
            sel = $urandom_range(0, 9);
            rd  = $urandom_range(0, 30);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            f3  = $urandom_range(0, 7);
            alt = $urandom_range(0, 1);
            case (sel)
                0, 1: imem[i] = enc_r((alt && (f3 == 0 || f3 == 5)) ? 32 : 0,
                                      rs2, rs1, f3, rd);
                2, 3: begin
                    imm = $urandom_range(0, 4095);
                    if (f3 == 1) imm = $urandom_range(0, 31);
                    if (f3 == 5) imm = (alt ? 1024 : 0) + $urandom_range(0, 31);
                    imem[i] = enc_i(imm, rs1, f3, rd, 7'h13);
                end
                4: imem[i] = enc_i(4 * $urandom_range(0, 31), alt ? 31 : 0,
                                   2, rd, 7'h03);
                5: imem[i] = enc_s(4 * $urandom_range(0, 31), rs2, alt ? 31 : 0);
                6: imem[i] = (i < n - 3) ?
                    enc_b(alt ? 8 : 12, bf3[$urandom_range(0, 5)], rs1, rs2) :
                    enc_i(0, 0, 0, 0, 7'h13);
                7: imem[i] = (i < n - 3) ? enc_j(alt ? 8 : 12, rd) :
                    enc_i(0, 0, 0, 0, 7'h13);
                8: imem[i] = {$urandom_range(0, 1048575) , 12'b0} |
                    {20'b0, rd[4:0], alt ? 7'h37 : 7'h17};
                default: imem[i] = {$urandom_range(0, 33554431), 7'h0b};
            endcase
        end
    endtask

    initial begin
        // Program from the basic dataflow scenario
        clear_imem();
        imem[0] = enc_i(10, 0, 0, 1, 7'h13);
        imem[1] = enc_i(20, 0, 0, 2, 7'h13);
        imem[2] = enc_r(0, 2, 1, 0, 3);
        imem[3] = enc_r(32, 1, 2, 0, 4);
        imem[4] = enc_s(0, 3, 0);
        imem[5] = enc_i(0, 0, 2, 5, 7'h03);
        imem[6] = enc_i(0, 0, 0, 0, 7'h13);
        imem[7] = enc_i(5, 5, 0, 6, 7'h13);
        run_phase("p1", 30);
        for (int k = 0; k < 8; k++)
            check($sformatf("p1_pc%0d", k), trace[k], 32'(4 * k));
        check("p1_x1", dut.rf[1], 32'd10);
        check("p1_x2", dut.rf[2], 32'd20);
        check("p1_x3", dut.rf[3], 32'd30);
        check("p1_x4", dut.rf[4], 32'd10);
        check("p1_x5", dut.rf[5], 32'd30);
        check("p1_x6", dut.rf[6], 32'd35);
        check("p1_mem0", dmem[0], 32'd30);

        // Load-use with no spacer: exactly one repeated fetch address
        clear_imem();
        imem[0] = enc_i(0, 0, 2, 5, 7'h03);
        imem[1] = enc_i(5, 5, 0, 6, 7'h13);
        imem[2] = enc_i(1, 0, 0, 7, 7'h13);
        imem[3] = enc_i(2, 0, 0, 8, 7'h13);
        run_phase("p2", 20);
        check("p2_pc1", trace[1], 32'd4);
        check("p2_pc2", trace[2], 32'd8);
        check("p2_pc3", trace[3], 32'd8);
        check("p2_pc4", trace[4], 32'd12);
        check("p2_pc5", trace[5], 32'd16);
        check("p2_x6", dut.rf[6], dmem_seed[0] + 32'd5);

        // Taken branch flushes the fall-through instruction
        clear_imem();
        imem[0] = enc_b(8, 0, 0, 0);
        imem[1] = enc_i(1, 0, 0, 9, 7'h13);
        imem[2] = enc_i(2, 0, 0, 10, 7'h13);
        run_phase("p3", 20);
        check("p3_pc2", trace[2], 32'd8);
        check("p3_pc3", trace[3], 32'd8);
        check("p3_pc4", trace[4], 32'd12);
        check("p3_x9", dut.rf[9], 32'd0);
        check("p3_x10", dut.rf[10], 32'd2);

        // JAL at 0x20, JALR to odd target, x0 protection
        clear_imem();
        for (int i = 0; i < 8; i++) imem[i] = enc_i(0, 0, 0, 0, 7'h13);
        imem[8]  = enc_j(12, 1);
        imem[9]  = enc_i(1, 0, 0, 11, 7'h13);
        imem[10] = enc_i(1, 0, 0, 12, 7'h13);
        imem[11] = enc_i(3, 0, 0, 13, 7'h13);
        imem[12] = enc_i(32'h41, 0, 0, 14, 7'h13);
        imem[13] = enc_i(0, 14, 0, 15, 7'h67);
        imem[14] = enc_i(1, 0, 0, 16, 7'h13);
        imem[15] = enc_i(1, 0, 0, 17, 7'h13);
        imem[16] = enc_i(7, 0, 0, 18, 7'h13);
        imem[17] = enc_i(5, 0, 0, 0, 7'h13);
        imem[18] = enc_r(0, 0, 0, 0, 7);
        run_phase("p4", 40);
        check("p4_x1", dut.rf[1], 32'h24);
        check("p4_x11", dut.rf[11], 32'd0);
        check("p4_x12", dut.rf[12], 32'd0);
        check("p4_x13", dut.rf[13], 32'd3);
        check("p4_x15", dut.rf[15], 32'h38);
        check("p4_x16", dut.rf[16], 32'd0);
        check("p4_x18", dut.rf[18], 32'd7);
        check("p4_x7", dut.rf[7], 32'd0);

        for (int t = 0; t < 4; t++) begin
            gen_random(40);
            run_phase($sformatf("rnd%0d", t), 150);
        end

        // Asynchronous reset mid-operation
        @(posedge clk);
        #2 rst = 0;
        #1;
        check("async_pc", imem_addr, 32'd0);
        check("async_we", {31'b0, core2dmem_req.wr_en}, 32'd0);
        check("async_re", {31'b0, core2dmem_req.rd_en}, 32'd0);
        check("async_x31", dut.rf[31], 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
